// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the IF/MEM memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned WORD_SIZE_DEF = 16;
  localparam int unsigned TIMEOUT_DEF   = 255;
  localparam int unsigned CNT_W         = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_WAIT = 2'd1,
    D_WAIT = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_mem_req_latch.sv
// Registered memory address/we/wdata with the grant mux (data side wins a tie).
module mem_req_latch
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned W = WORD_SIZE_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load_if,
  input  logic         i_load_d,
  input  logic [W-1:0] i_if_addr,
  input  logic         i_d_we,
  input  logic [W-1:0] i_d_addr,
  input  logic [W-1:0] i_d_wdata,
  output logic         o_mem_we,
  output logic [W-1:0] o_mem_addr,
  output logic [W-1:0] o_mem_wdata
);

  logic         r_we;
  logic [W-1:0] r_addr;
  logic [W-1:0] r_wdata;

  // Sample the granted requester's payload on the grant edge only
  always_ff @(posedge clk) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (i_load_d) begin
      r_we    <= i_d_we;
      r_addr  <= i_d_addr;
      r_wdata <= i_d_wdata;
    end else if (i_load_if) begin
      r_we    <= 1'b0;
      r_addr  <= i_if_addr;
      r_wdata <= '0;
    end
  end

  assign o_mem_we    = r_we;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data access.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned WORD_SIZE = WORD_SIZE_DEF,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic                 i_valid,
  output logic [WORD_SIZE-1:0] i_data,
  output logic                 i_stall,
  input  logic                 flush,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic                 d_valid,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_stall,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 mem_ack,
  output logic                 mem_err
);

  arb_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_drop;

  logic w_d_want;
  logic w_i_want;
  logic w_grant_d;
  logic w_grant_i;
  logic w_timeout;

  // A requester whose valid is showing is still holding req for the finished access, so mask it
  assign w_d_want  = d_req & ~d_valid & ~mem_err;
  assign w_i_want  = i_req & ~i_valid & ~flush & ~mem_err;
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

  // Grant decision: from IDLE either side, on completion only the other side (no bubble)
  always_comb begin
    w_grant_d = 1'b0;
    w_grant_i = 1'b0;
    case (r_state)
      IDLE: begin
        w_grant_d = w_d_want;
        w_grant_i = ~w_d_want & w_i_want;
      end
      I_WAIT:  w_grant_d = mem_ack & w_d_want;
      D_WAIT:  w_grant_i = mem_ack & w_i_want;
      default: begin
        w_grant_d = 1'b0;
        w_grant_i = 1'b0;
      end
    endcase
  end

  // Arbiter FSM with timeout counter, fetch drop flag and registered responses
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_drop  <= 1'b0;
      mem_req <= 1'b0;
      mem_err <= 1'b0;
      i_valid <= 1'b0;
      i_data  <= '0;
      d_valid <= 1'b0;
      d_rdata <= '0;
    end else begin
      i_valid <= 1'b0;
      d_valid <= 1'b0;
      case (r_state)
        I_WAIT: begin
          if (flush) r_drop <= 1'b1;
          if (mem_ack) begin
            mem_req <= 1'b0;
            r_state <= IDLE;
            if (!(r_drop || flush)) begin
              i_valid <= 1'b1;
              i_data  <= mem_rdata;
            end
          end else if (w_timeout) begin
            mem_err <= 1'b1;
            mem_req <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        D_WAIT: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            r_state <= IDLE;
            d_valid <= 1'b1;
            if (!mem_we) d_rdata <= mem_rdata;
          end else if (w_timeout) begin
            mem_err <= 1'b1;
            mem_req <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
      if (w_grant_d) begin
        r_state <= D_WAIT;
        mem_req <= 1'b1;
        r_cnt   <= '0;
        r_drop  <= 1'b0;
      end else if (w_grant_i) begin
        r_state <= I_WAIT;
        mem_req <= 1'b1;
        r_cnt   <= '0;
        r_drop  <= 1'b0;
      end
    end
  end

  assign i_stall = i_req & ~i_valid;
  assign d_stall = d_req & ~d_valid;

  mem_req_latch #(.W(WORD_SIZE)) u_req_latch (
    .clk         (clk),
    .reset       (reset),
    .i_load_if   (w_grant_i),
    .i_load_d    (w_grant_d),
    .i_if_addr   (i_addr),
    .i_d_we      (d_we),
    .i_d_addr    (d_addr),
    .i_d_wdata   (d_wdata),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench with a response scoreboard for mem_port_arbiter.
module tb_mem_port_arbiter;

  localparam int unsigned W = 16;

  typedef struct {
    bit           is_d;
    logic [W-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  logic         clk = 1'b0;
  logic         reset;
  logic         i_req, flush, d_req, d_we, mem_ack;
  logic [W-1:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic         i_valid, i_stall, d_valid, d_stall, mem_req, mem_we, mem_err;
  logic [W-1:0] i_data, d_rdata, mem_addr, mem_wdata;

  logic         t_reset;
  logic         t_i_req, t_flush, t_d_req, t_d_we, t_mem_ack;
  logic [W-1:0] t_i_addr, t_d_addr, t_d_wdata, t_mem_rdata;
  logic         t_i_valid, t_i_stall, t_d_valid, t_d_stall, t_mem_req, t_mem_we, t_mem_err;
  logic [W-1:0] t_i_data, t_d_rdata, t_mem_addr, t_mem_wdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WORD_SIZE(W), .TIMEOUT(255)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_valid(i_valid), .i_data(i_data), .i_stall(i_stall),
    .flush(flush),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_valid(d_valid), .d_rdata(d_rdata), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_err(mem_err)
  );

  mem_port_arbiter #(.WORD_SIZE(W), .TIMEOUT(4)) dut_to (
    .clk(clk), .reset(t_reset),
    .i_req(t_i_req), .i_addr(t_i_addr), .i_valid(t_i_valid), .i_data(t_i_data), .i_stall(t_i_stall),
    .flush(t_flush),
    .d_req(t_d_req), .d_we(t_d_we), .d_addr(t_d_addr), .d_wdata(t_d_wdata),
    .d_valid(t_d_valid), .d_rdata(t_d_rdata), .d_stall(t_d_stall),
    .mem_req(t_mem_req), .mem_we(t_mem_we), .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata),
    .mem_rdata(t_mem_rdata), .mem_ack(t_mem_ack), .mem_err(t_mem_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Response monitor: every valid pulse must match the oldest expected response
  always @(negedge clk) begin
    exp_t e;
    if (i_valid && d_valid) check("valid_overlap", 32'(1), 32'(0));
    if (d_valid) begin
      if (exp_q.size() == 0) check("unexpected_d_valid", 32'(1), 32'(0));
      else begin
        e = exp_q.pop_front();
        check("order_d", 32'(e.is_d), 32'(1));
        check("d_rdata", 32'(d_rdata), 32'(e.data));
      end
    end
    if (i_valid) begin
      if (exp_q.size() == 0) check("unexpected_i_valid", 32'(1), 32'(0));
      else begin
        e = exp_q.pop_front();
        check("order_i", 32'(e.is_d), 32'(0));
        check("i_data", 32'(i_data), 32'(e.data));
      end
    end
  end

  initial begin
    reset = 1'b1; i_req = 0; flush = 0; d_req = 0; d_we = 0; mem_ack = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    t_reset = 1'b1; t_i_req = 0; t_flush = 0; t_d_req = 0; t_d_we = 0; t_mem_ack = 0;
    t_i_addr = '0; t_d_addr = '0; t_d_wdata = '0; t_mem_rdata = '0;
    tick(); tick();
    reset = 1'b0;

    // reset state
    check("rst_mem_req", 32'(mem_req), 32'(0));
    check("rst_mem_we", 32'(mem_we), 32'(0));
    check("rst_mem_addr", 32'(mem_addr), 32'(0));
    check("rst_mem_err", 32'(mem_err), 32'(0));
    check("rst_i_valid", 32'(i_valid), 32'(0));
    check("rst_d_valid", 32'(d_valid), 32'(0));

    // 1: single fetch, ack in first cycle
    i_req = 1; i_addr = 16'h0010;
    tick();
    check("t1_mem_req", 32'(mem_req), 32'(1));
    check("t1_mem_addr", 32'(mem_addr), 32'h0010);
    check("t1_mem_we", 32'(mem_we), 32'(0));
    check("t1_i_stall", 32'(i_stall), 32'(1));
    mem_ack = 1; mem_rdata = 16'hABCD;
    exp_q.push_back('{is_d: 1'b0, data: 16'hABCD});
    tick();
    mem_ack = 0;
    check("t1_mem_req_drop", 32'(mem_req), 32'(0));
    check("t1_i_valid", 32'(i_valid), 32'(1));
    check("t1_i_stall_low", 32'(i_stall), 32'(0));
    i_req = 0;
    tick();
    check("t1_i_valid_pulse", 32'(i_valid), 32'(0));

    // 2: simultaneous requests, store wins, fetch follows with no bubble
    i_req = 1; i_addr = 16'h0020;
    d_req = 1; d_we = 1; d_addr = 16'h0200; d_wdata = 16'h1234;
    tick();
    check("t2_mem_we", 32'(mem_we), 32'(1));
    check("t2_mem_addr", 32'(mem_addr), 32'h0200);
    check("t2_mem_wdata", 32'(mem_wdata), 32'h1234);
    check("t2_d_stall", 32'(d_stall), 32'(1));
    mem_ack = 1; mem_rdata = 16'hDEAD;
    exp_q.push_back('{is_d: 1'b1, data: 16'h0000});
    tick();
    check("t2_d_valid", 32'(d_valid), 32'(1));
    check("t2_i_grant_req", 32'(mem_req), 32'(1));
    check("t2_i_grant_we", 32'(mem_we), 32'(0));
    check("t2_i_grant_addr", 32'(mem_addr), 32'h0020);
    d_req = 0; d_we = 0;
    mem_rdata = 16'h5555;
    exp_q.push_back('{is_d: 1'b0, data: 16'h5555});
    tick();
    mem_ack = 0; i_req = 0;
    check("t2_i_valid", 32'(i_valid), 32'(1));
    check("t2_mem_req_low", 32'(mem_req), 32'(0));
    tick();

    // 3: fetch flushed in flight, new fetch granted right after the ack
    i_req = 1; i_addr = 16'h0030;
    tick();
    flush = 1;
    tick();
    flush = 0;
    tick();
    mem_ack = 1; mem_rdata = 16'h7777; i_addr = 16'h0040;
    tick();
    mem_ack = 0;
    check("t3_no_i_valid", 32'(i_valid), 32'(0));
    check("t3_idle_mem_req", 32'(mem_req), 32'(0));
    tick();
    check("t3_regrant_req", 32'(mem_req), 32'(1));
    check("t3_regrant_addr", 32'(mem_addr), 32'h0040);
    mem_ack = 1; mem_rdata = 16'h4444;
    exp_q.push_back('{is_d: 1'b0, data: 16'h4444});
    tick();
    mem_ack = 0; i_req = 0;
    check("t3_i_valid", 32'(i_valid), 32'(1));
    tick();

    // 4: load with ack in the fifth wait cycle
    d_req = 1; d_we = 0; d_addr = 16'h0300;
    tick();
    check("t4_mem_addr", 32'(mem_addr), 32'h0300);
    check("t4_mem_we", 32'(mem_we), 32'(0));
    for (int k = 0; k < 4; k++) begin
      check("t4_d_stall", 32'(d_stall), 32'(1));
      check("t4_mem_req", 32'(mem_req), 32'(1));
      tick();
    end
    mem_ack = 1; mem_rdata = 16'hBEEF;
    check("t4_d_stall_ack", 32'(d_stall), 32'(1));
    exp_q.push_back('{is_d: 1'b1, data: 16'hBEEF});
    tick();
    mem_ack = 0; mem_rdata = 16'h0000;
    check("t4_d_valid", 32'(d_valid), 32'(1));
    check("t4_d_stall_low", 32'(d_stall), 32'(0));
    d_req = 0;
    tick();
    check("t4_d_valid_pulse", 32'(d_valid), 32'(0));
    check("t4_d_rdata_hold", 32'(d_rdata), 32'hBEEF);

    // 5: reset during D_WAIT, stale ack afterwards
    d_req = 1; d_we = 0; d_addr = 16'h0400;
    tick();
    check("t5_in_wait", 32'(mem_req), 32'(1));
    reset = 1; d_req = 0;
    tick();
    reset = 0;
    mem_ack = 1; mem_rdata = 16'h9999;
    check("t5_mem_req", 32'(mem_req), 32'(0));
    check("t5_mem_addr", 32'(mem_addr), 32'(0));
    check("t5_i_data", 32'(i_data), 32'(0));
    check("t5_d_rdata", 32'(d_rdata), 32'(0));
    tick();
    mem_ack = 0;
    check("t5_stale_d_valid", 32'(d_valid), 32'(0));
    check("t5_stale_d_rdata", 32'(d_rdata), 32'(0));
    tick();
    check("t5_idle_mem_req", 32'(mem_req), 32'(0));

    // 6: ack timeout on the TIMEOUT=4 instance
    t_reset = 0;
    t_d_req = 1; t_d_addr = 16'h0500;
    tick();
    check("t6_mem_req", 32'(t_mem_req), 32'(1));
    tick(); tick(); tick();
    check("t6_err_not_yet", 32'(t_mem_err), 32'(0));
    check("t6_req_still", 32'(t_mem_req), 32'(1));
    tick();
    check("t6_mem_err", 32'(t_mem_err), 32'(1));
    check("t6_mem_req_low", 32'(t_mem_req), 32'(0));
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t6_err_sticky", 32'(t_mem_err), 32'(1));
      check("t6_no_regrant", 32'(t_mem_req), 32'(0));
      check("t6_d_stall", 32'(t_d_stall), 32'(1));
    end
    t_reset = 1; t_d_req = 0;
    tick();
    t_reset = 0;
    check("t6_err_cleared", 32'(t_mem_err), 32'(0));

    tick();
    check("sb_empty", 32'(exp_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
